echo_cancel: RTL
================

// Module: echo_cancel
// PURPOSE
// Inverse of the echo stage: removes a single delayed, attenuated echo from a valid-qualified sample stream.
// Computes x[n] = y[n] - g*x[n-D] recursively, so an echoed stream y[n] = x[n] + g*x[n-D] is restored exactly.
// Sits directly downstream of the echo stage in the audio path.
// Delay and gain are runtime-configurable.
// PARAMETERS
// DATA_WIDTH_IN   32   width of i_data; signed two's complement
// DATA_WIDTH_OUT  32   width of o_data; signed; must be >= DATA_WIDTH_IN
// DELAY_MAX       100  history depth in samples; largest legal D
// GAIN_W          16   gain width; unsigned Q1.(GAIN_W-1); legal range 0..2^(GAIN_W-1), i.e. 0.0..1.0
// PORTS
// i_clk      in   1                      clock; all logic rises on posedge
// i_rst_n    in   1                      reset
// i_cfg_we   in   1                      load i_delay and i_gain; flush history
// i_delay    in   $clog2(DELAY_MAX+1)    echo delay D in samples
// i_gain     in   GAIN_W                 echo gain g
// i_valid    in   1                      i_data carries a sample this cycle
// i_data     in   DATA_WIDTH_IN          echoed sample y[n]
// o_valid    out  1                      o_data carries a sample this cycle
// o_data     out  DATA_WIDTH_OUT         recovered sample x[n]
// BEHAVIOUR
// Clocking/reset: one clock; reset is asynchronous and active-low.
// - While i_rst_n=0: o_valid=0, o_data=0, cfg D=0, g=0, wr_ptr=0, fill=0.
// Latency and flow control:
// - Fixed latency of 1 cycle: o_valid(t+1) = i_valid(t).
// - No backpressure. Gaps on i_valid are allowed and do not advance history.
// - o_data holds its last value while o_valid=0.
// Config:
// - i_cfg_we=1 registers D_cfg = min(i_delay, DELAY_MAX) and g_cfg = min(i_gain, 2^(GAIN_W-1)).
// - It also clears fill to 0, which flushes history.
// - If i_valid is high in the same cycle, that sample uses the NEW config with empty history.
// History:
// - Circular buffer of DELAY_MAX recovered outputs x (not inputs).
// - wr_ptr advances by 1 per valid sample and wraps DELAY_MAX-1 -> 0.
// - Read index = (wr_ptr - D_cfg) mod DELAY_MAX, with the wrap computed without a divider.
// - fill is a saturating count of samples since the last flush/reset, capped at DELAY_MAX.
// - h = buf[rd_idx] if fill >= D_cfg, else 0. Stale RAM contents must never leak out.
// - D_cfg=0: bypass, x = sign-extended y; history is still written.
// - D_cfg=1 with back-to-back valids: h is the sample produced in the previous cycle.
//   The previous output must be available (forwarded or write-first) in the same cycle.
// Arithmetic:
// - p = h * g_cfg, signed x unsigned, width DATA_WIDTH_OUT+GAIN_W+1.
// - e = p >>> (GAIN_W-1), arithmetic shift, truncating toward -inf.
// - d = sext(y) - e, computed at DATA_WIDTH_OUT+2 bits.
// - x = d saturated to [-2^(DATA_WIDTH_OUT-1), 2^(DATA_WIDTH_OUT-1)-1].
// - The saturated x is what gets written to history.
// Boundaries:
// - Reset mid-stream drops the in-flight sample; the first post-reset sample sees empty history.
// - i_cfg_we without i_valid changes nothing else.
// STRUCTURE
// Shared package echo_pkg:
// - DELAY_MAX and GAIN_W defaults.
// - Function sat_signed(value, width).
// - Function ptr_sub_wrap(ptr, d, depth).
// Sub-module echo_history_ram:
// - DELAY_MAX x DATA_WIDTH_OUT buffer, 1 write port and 1 asynchronous read port, write-first bypass.
// - No reset on the array.
// Top level holds: config registers, wr_ptr, fill counter, MAC/saturate datapath, output registers.
// TESTING
// 1. Reset: hold i_rst_n=0 with i_valid=1, i_data=5 -> o_valid=0 and o_data=0 every cycle; release -> first output is 5.
// 2. Impulse: D=3, g=0x4000 (0.5, GAIN_W=16); y=1000,0,0,500,0,0 -> x=1000,0,0,0,0,0.
// 3. Recursion: D=1, g=0x8000 (1.0); y=10,10,10,10 back-to-back -> x=10,0,10,0.
// 4. Saturation: D=1, g=1.0, y=-2^31 then +2^31-1 -> x=-2^31, then saturates to 2^31-1.
// 5. Flush: D=2 stream of y=100 running; pulse i_cfg_we with D=2 alongside a valid y=100 -> x=100,100, then history resumes.
// 6. Wrap: D=100, g=0.5, 250 random valid samples with random i_valid gaps fed through the echo stage -> output matches the original stream bit-exact.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared definitions for the echo cancel path.
// Holds the default history depth and gain width, plus two helpers:
//   sat_signed    - clamps a signed value to the range of a narrower signed width
//   ptr_sub_wrap  - circular-buffer pointer subtraction without a divider
package echo_pkg;

    localparam int DELAY_MAX_DEF = 100;
    localparam int GAIN_W_DEF    = 16;

    // Clamp value to [-2^(width-1), 2^(width-1)-1]; width must be 2..63.
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] value,
        input int unsigned        width
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    // (ptr - d) mod depth for ptr < depth and d <= depth.
    function automatic logic [15:0] ptr_sub_wrap(
        input logic [15:0] ptr,
        input logic [15:0] d,
        input logic [15:0] depth
    );
        return (ptr >= d) ? (ptr - d) : (ptr + depth - d);
    endfunction

endpackage

// File: rtl/echo_history_ram.sv
// History buffer of recovered samples for echo_cancel.
// One synchronous write port, one asynchronous read port, no reset on the array.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data (combinational from the array)
module echo_history_ram #(
    parameter int DEPTH = 100,
    parameter int WIDTH = 32,
    parameter int AW    = 7
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // A sample written at an edge is visible here for the whole next cycle,
    // which gives the write-first behaviour needed for a delay of 1. No
    // same-cycle forward is added: at delay DEPTH the read address equals the
    // write address and the old contents are the ones wanted.
    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/echo_cancel.sv
// Echo canceller: recovers x[n] = y[n] - g*x[n-D] from an echoed, valid-qualified
// sample stream. D and g are loaded at runtime; loading them flushes history.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_cfg_we           load i_delay / i_gain (clamped), flush history
//   i_delay, i_gain    echo delay in samples, unsigned Q1.(GAIN_W-1) gain
//   i_valid, i_data    echoed input sample y[n]
//   o_valid, o_data    recovered sample x[n], one cycle after the input
module echo_cancel
    import echo_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = 32,
    parameter int DATA_WIDTH_OUT = 32,
    parameter int DELAY_MAX      = DELAY_MAX_DEF,
    parameter int GAIN_W         = GAIN_W_DEF
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_cfg_we,
    input  logic [$clog2(DELAY_MAX+1)-1:0]   i_delay,
    input  logic [GAIN_W-1:0]                i_gain,
    input  logic                             i_valid,
    input  logic [DATA_WIDTH_IN-1:0]         i_data,
    output logic                             o_valid,
    output logic [DATA_WIDTH_OUT-1:0]        o_data
);

    localparam int DLY_W  = $clog2(DELAY_MAX + 1);
    localparam int PTR_W  = (DELAY_MAX > 1) ? $clog2(DELAY_MAX) : 1;
    localparam int PROD_W = DATA_WIDTH_OUT + GAIN_W + 1;
    localparam int DIFF_W = DATA_WIDTH_OUT + 2;

    localparam logic [GAIN_W-1:0] GAIN_ONE  = {1'b1, {(GAIN_W-1){1'b0}}};
    localparam logic [DLY_W-1:0]  DLY_MAX_V = DLY_W'(DELAY_MAX);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DELAY_MAX - 1);

    logic [DLY_W-1:0]          d_cfg_q, d_cfg_d;
    logic [GAIN_W-1:0]         g_cfg_q, g_cfg_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [DLY_W-1:0]          fill_q, fill_d;
    logic                      o_valid_q, o_valid_d;
    logic [DATA_WIDTH_OUT-1:0] o_data_q, o_data_d;

    logic [DLY_W-1:0]          d_eff;
    logic [GAIN_W-1:0]         g_eff;
    logic [DLY_W-1:0]          fill_eff;
    logic [PTR_W-1:0]          rd_idx;
    logic [DATA_WIDTH_OUT-1:0] rd_data;
    logic [DATA_WIDTH_OUT-1:0] hist;
    logic signed [PROD_W-1:0]  h_ext, g_ext, prod, echo;
    logic signed [DIFF_W-1:0]  diff;
    logic [DATA_WIDTH_OUT-1:0] x;

    echo_history_ram #(
        .DEPTH (DELAY_MAX),
        .WIDTH (DATA_WIDTH_OUT),
        .AW    (PTR_W)
    ) u_hist (
        .i_clk   (i_clk),
        .i_we    (i_valid),
        .i_waddr (wr_ptr_q),
        .i_wdata (x),
        .i_raddr (rd_idx),
        .o_rdata (rd_data)
    );

    // A config write takes effect for a sample arriving in the same cycle,
    // so the datapath works on the effective (not yet registered) values.
    always_comb begin
        d_eff    = d_cfg_q;
        g_eff    = g_cfg_q;
        fill_eff = fill_q;
        if (i_cfg_we) begin
            d_eff    = (i_delay > DLY_MAX_V) ? DLY_MAX_V : i_delay;
            g_eff    = (i_gain > GAIN_ONE) ? GAIN_ONE : i_gain;
            fill_eff = '0;
        end

        rd_idx = PTR_W'(ptr_sub_wrap(16'(wr_ptr_q), 16'(d_eff), 16'(DELAY_MAX)));

        // Only entries written since the last flush may contribute; D=0 is bypass.
        hist = ((d_eff != '0) && (fill_eff >= d_eff)) ? rd_data : '0;

        h_ext = PROD_W'($signed(hist));
        g_ext = PROD_W'($signed({1'b0, g_eff}));
        prod  = h_ext * g_ext;
        echo  = prod >>> (GAIN_W - 1);
        diff  = DIFF_W'($signed(i_data)) - DIFF_W'(echo);
        x     = DATA_WIDTH_OUT'(sat_signed(64'(diff), DATA_WIDTH_OUT));
    end

    always_comb begin
        d_cfg_d   = d_cfg_q;
        g_cfg_d   = g_cfg_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_eff;
        o_valid_d = i_valid;
        o_data_d  = o_data_q;

        if (i_cfg_we) begin
            d_cfg_d = d_eff;
            g_cfg_d = g_eff;
        end

        if (i_valid) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            if (fill_eff < DLY_MAX_V) begin
                fill_d = fill_eff + DLY_W'(1);
            end
            o_data_d = x;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            d_cfg_q   <= '0;
            g_cfg_q   <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else begin
            d_cfg_q   <= d_cfg_d;
            g_cfg_q   <= g_cfg_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;

endmodule
